// File: rtl/ccu_snoop_gate_pkg.sv
// Shared ACE snoop/write-monitor types and constants for the CCU snoop gate.
package ccu_snoop_gate_pkg;

    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int LINE_OFFSET       = $clog2(DCACHE_LINE_WIDTH / 8);
    localparam int CR_DATA_TRANSFER  = 0;
    localparam int ACE_ADDR_WIDTH    = 64;
    localparam int ACE_DATA_WIDTH    = 64;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_CR = 2'd1;
    localparam logic [1:0] ST_WAIT_CD = 2'd2;

    typedef struct packed {
        logic [ACE_ADDR_WIDTH-1:0] addr;
    } ace_ac_chan_t;

    typedef struct packed {
        logic [ACE_DATA_WIDTH-1:0] data;
        logic                      last;
    } ace_cd_chan_t;

    typedef struct packed {
        logic         ac_valid;
        ace_ac_chan_t ac;
        logic         cr_ready;
        logic         cd_ready;
    } ace_snoop_req_t;

    typedef struct packed {
        logic         ac_ready;
        logic         cr_valid;
        logic [4:0]   cr_resp;
        logic         cd_valid;
        ace_cd_chan_t cd;
    } ace_snoop_resp_t;

    typedef struct packed {
        logic [ACE_ADDR_WIDTH-1:0] addr;
    } ace_aw_chan_t;

    typedef struct packed {
        logic         aw_valid;
        ace_aw_chan_t aw;
        logic         b_ready;
    } ace_req_t;

    typedef struct packed {
        logic aw_ready;
        logic b_valid;
    } ace_resp_t;

endpackage

// File: rtl/ccu_snoop_gate_port.sv
// Single-port snoop gate: one-outstanding-snoop FSM plus write-back line tracker.
module ccu_snoop_gate_port
    import ccu_snoop_gate_pkg::*;
#(
    parameter int  AxiAddrWidth = 64,
    parameter int  LineOffset   = LINE_OFFSET,
    parameter type req_t        = ace_req_t,
    parameter type resp_t       = ace_resp_t,
    parameter type snoop_req_t  = ace_snoop_req_t,
    parameter type snoop_resp_t = ace_snoop_resp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  snoop_req_t  ccu_snoop_req_i,
    output snoop_resp_t ccu_snoop_resp_o,
    output snoop_req_t  core_snoop_req_o,
    input  snoop_resp_t core_snoop_resp_i,
    input  req_t        core_req_i,
    input  resp_t       core_resp_i
);

    logic [1:0]                         state_q, state_d;
    logic [1:0]                         wb_cnt_q, wb_cnt_d;
    logic [AxiAddrWidth-LineOffset-1:0] wb_line_q, wb_line_d;
    logic                               conflict;
    logic                               aw_hs, b_hs;
    logic                               unused_low_bits;

    assign unused_low_bits = ^{core_req_i.aw.addr[LineOffset-1:0],
                               ccu_snoop_req_i.ac.addr[LineOffset-1:0]};

    assign aw_hs    = core_req_i.aw_valid & core_resp_i.aw_ready;
    assign b_hs     = core_resp_i.b_valid & core_req_i.b_ready;
    assign conflict = (wb_cnt_q != 2'd0) &&
                      (ccu_snoop_req_i.ac.addr[AxiAddrWidth-1:LineOffset] == wb_line_q);

    // Payloads pass straight through; only the handshake signals are gated.
    always_comb begin
        core_snoop_req_o          = ccu_snoop_req_i;
        ccu_snoop_resp_o          = core_snoop_resp_i;
        core_snoop_req_o.ac_valid = 1'b0;
        core_snoop_req_o.cr_ready = 1'b0;
        core_snoop_req_o.cd_ready = 1'b0;
        ccu_snoop_resp_o.ac_ready = 1'b0;
        ccu_snoop_resp_o.cr_valid = 1'b0;
        ccu_snoop_resp_o.cd_valid = 1'b0;
        state_d                   = state_q;
        case (state_q)
            ST_IDLE: begin
                core_snoop_req_o.ac_valid = ccu_snoop_req_i.ac_valid & ~conflict;
                ccu_snoop_resp_o.ac_ready = core_snoop_resp_i.ac_ready & ~conflict;
                if (ccu_snoop_req_i.ac_valid && core_snoop_resp_i.ac_ready && !conflict)
                    state_d = ST_WAIT_CR;
            end
            ST_WAIT_CR: begin
                ccu_snoop_resp_o.cr_valid = core_snoop_resp_i.cr_valid;
                core_snoop_req_o.cr_ready = ccu_snoop_req_i.cr_ready;
                if (core_snoop_resp_i.cr_valid && ccu_snoop_req_i.cr_ready)
                    state_d = core_snoop_resp_i.cr_resp[CR_DATA_TRANSFER] ? ST_WAIT_CD : ST_IDLE;
            end
            ST_WAIT_CD: begin
                ccu_snoop_resp_o.cd_valid = core_snoop_resp_i.cd_valid;
                core_snoop_req_o.cd_ready = ccu_snoop_req_i.cd_ready;
                if (core_snoop_resp_i.cd_valid && ccu_snoop_req_i.cd_ready &&
                    core_snoop_resp_i.cd.last)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs must drop the moment reset asserts, not at the next edge.
        if (rst_i) begin
            core_snoop_req_o.ac_valid = 1'b0;
            core_snoop_req_o.cr_ready = 1'b0;
            core_snoop_req_o.cd_ready = 1'b0;
            ccu_snoop_resp_o.ac_ready = 1'b0;
            ccu_snoop_resp_o.cr_valid = 1'b0;
            ccu_snoop_resp_o.cd_valid = 1'b0;
        end
    end

    always_comb begin
        wb_cnt_d  = wb_cnt_q;
        wb_line_d = wb_line_q;
        if (aw_hs)
            wb_line_d = core_req_i.aw.addr[AxiAddrWidth-1:LineOffset];
        if (aw_hs && !b_hs && wb_cnt_q != 2'd3)
            wb_cnt_d = wb_cnt_q + 2'd1;
        else if (b_hs && !aw_hs && wb_cnt_q != 2'd0)
            wb_cnt_d = wb_cnt_q - 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            wb_cnt_q  <= 2'd0;
            wb_line_q <= '0;
        end else begin
            state_q   <= state_d;
            wb_cnt_q  <= wb_cnt_d;
            wb_line_q <= wb_line_d;
        end
    end

    a_wb_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(aw_hs && !b_hs && wb_cnt_q == 2'd3));
    a_wb_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(b_hs && !aw_hs && wb_cnt_q == 2'd0));

endmodule

// File: rtl/ccu_snoop_gate.sv
// Per-port ACE snoop gate between the CCU and the cores; ports are fully independent.
module ccu_snoop_gate
    import ccu_snoop_gate_pkg::*;
#(
    parameter int  NoPorts      = 2,
    parameter int  AxiAddrWidth = 64,
    parameter int  LineOffset   = LINE_OFFSET,
    parameter type req_t        = ace_req_t,
    parameter type resp_t       = ace_resp_t,
    parameter type snoop_req_t  = ace_snoop_req_t,
    parameter type snoop_resp_t = ace_snoop_resp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  snoop_req_t  ccu_snoop_req_i   [NoPorts],
    output snoop_resp_t ccu_snoop_resp_o  [NoPorts],
    output snoop_req_t  core_snoop_req_o  [NoPorts],
    input  snoop_resp_t core_snoop_resp_i [NoPorts],
    input  req_t        core_req_i        [NoPorts],
    input  resp_t       core_resp_i       [NoPorts]
);

    for (genvar gi = 0; gi < NoPorts; gi++) begin : g_port
        ccu_snoop_gate_port #(
            .AxiAddrWidth (AxiAddrWidth),
            .LineOffset   (LineOffset),
            .req_t        (req_t),
            .resp_t       (resp_t),
            .snoop_req_t  (snoop_req_t),
            .snoop_resp_t (snoop_resp_t)
        ) u_port (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .ccu_snoop_req_i   (ccu_snoop_req_i[gi]),
            .ccu_snoop_resp_o  (ccu_snoop_resp_o[gi]),
            .core_snoop_req_o  (core_snoop_req_o[gi]),
            .core_snoop_resp_i (core_snoop_resp_i[gi]),
            .core_req_i        (core_req_i[gi]),
            .core_resp_i       (core_resp_i[gi])
        );
    end

endmodule

// File: tb/tb_ccu_snoop_gate.sv
// Directed bench for ccu_snoop_gate: snoop flows, write-back conflicts, port independence, reset.
module tb_ccu_snoop_gate;
    import ccu_snoop_gate_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    ace_snoop_req_t  ccu_req   [2];
    ace_snoop_resp_t ccu_resp  [2];
    ace_snoop_req_t  core_req  [2];
    ace_snoop_resp_t core_resp [2];
    ace_req_t        creq      [2];
    ace_resp_t       cresp     [2];
    int              total = 0;
    int              bad   = 0;

    always #5 clk = ~clk;

    ccu_snoop_gate #(.NoPorts(2)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ccu_snoop_req_i   (ccu_req),
        .ccu_snoop_resp_o  (ccu_resp),
        .core_snoop_req_o  (core_req),
        .core_snoop_resp_i (core_resp),
        .core_req_i        (creq),
        .core_resp_i       (cresp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        for (int p = 0; p < 2; p++) begin
            ccu_req[p]   = '0;
            core_resp[p] = '0;
            creq[p]      = '0;
            cresp[p]     = '0;
        end
    endtask

    task automatic aw_push(input int p, input logic [63:0] addr);
        creq[p].aw_valid = 1'b1;
        creq[p].aw.addr  = addr;
        cresp[p].aw_ready = 1'b1;
        tick();
        creq[p].aw_valid = 1'b0;
        cresp[p].aw_ready = 1'b0;
    endtask

    task automatic finish_cr(input int p);
        ccu_req[p].ac_valid  = 1'b0;
        core_resp[p].cr_valid = 1'b1;
        core_resp[p].cr_resp  = 5'h00;
        ccu_req[p].cr_ready  = 1'b1;
        tick();
        core_resp[p].cr_valid = 1'b0;
        ccu_req[p].cr_ready  = 1'b0;
    endtask

    task automatic test_reset();
        ccu_req[0].ac_valid   = 1'b1;
        core_resp[0].ac_ready = 1'b1;
        core_resp[0].cr_valid = 1'b1;
        ccu_req[0].cr_ready   = 1'b1;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL rst_ac_valid: got %0b want 0", core_req[0].ac_valid); end
        total++; if (ccu_resp[0].ac_ready !== 1'b0) begin bad++; $display("FAIL rst_ac_ready: got %0b want 0", ccu_resp[0].ac_ready); end
        total++; if (ccu_resp[0].cr_valid !== 1'b0) begin bad++; $display("FAIL rst_cr_valid: got %0b want 0", ccu_resp[0].cr_valid); end
        clr_inputs();
        tick();
        rst = 1'b0;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_plain();
        ccu_req[0].ac_valid   = 1'b1;
        ccu_req[0].ac.addr    = 64'h8000_0040;
        core_resp[0].ac_ready = 1'b1;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL plain_ac_fwd: got %0b want 1", core_req[0].ac_valid); end
        total++; if (core_req[0].ac.addr !== 64'h8000_0040) begin bad++; $display("FAIL plain_ac_addr: got %h want 80000040", core_req[0].ac.addr); end
        total++; if (ccu_resp[0].ac_ready !== 1'b1) begin bad++; $display("FAIL plain_ac_ready: got %0b want 1", ccu_resp[0].ac_ready); end
        tick();
        ccu_req[0].ac.addr    = 64'h8000_0100;
        core_resp[0].cr_valid = 1'b1;
        core_resp[0].cr_resp  = 5'h00;
        ccu_req[0].cr_ready   = 1'b1;
        #1;
        total++; if (ccu_resp[0].cr_valid !== 1'b1) begin bad++; $display("FAIL plain_cr_valid: got %0b want 1", ccu_resp[0].cr_valid); end
        total++; if (ccu_resp[0].cr_resp !== 5'h00) begin bad++; $display("FAIL plain_cr_resp: got %h want 00", ccu_resp[0].cr_resp); end
        total++; if (core_req[0].cr_ready !== 1'b1) begin bad++; $display("FAIL plain_cr_ready: got %0b want 1", core_req[0].cr_ready); end
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL plain_ac_blocked: got %0b want 0", core_req[0].ac_valid); end
        total++; if (ccu_resp[0].ac_ready !== 1'b0) begin bad++; $display("FAIL plain_ac_rdy_blocked: got %0b want 0", ccu_resp[0].ac_ready); end
        tick();
        core_resp[0].cr_valid = 1'b0;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL plain_second_ac: got %0b want 1", core_req[0].ac_valid); end
        total++; if (ccu_resp[0].ac_ready !== 1'b1) begin bad++; $display("FAIL plain_second_rdy: got %0b want 1", ccu_resp[0].ac_ready); end
        tick();
        finish_cr(0);
        clr_inputs();
        $display("test_plain: snoop 80000040 + 80000100 done");
    endtask

    task automatic test_data();
        ccu_req[0].ac_valid   = 1'b1;
        ccu_req[0].ac.addr    = 64'h8000_0080;
        core_resp[0].ac_ready = 1'b1;
        tick();
        ccu_req[0].ac_valid   = 1'b0;
        core_resp[0].cr_valid = 1'b1;
        core_resp[0].cr_resp  = 5'h01;
        ccu_req[0].cr_ready   = 1'b1;
        core_resp[0].cd_valid = 1'b1;
        core_resp[0].cd.data  = 64'h11;
        core_resp[0].cd.last  = 1'b0;
        ccu_req[0].cd_ready   = 1'b1;
        #1;
        total++; if (ccu_resp[0].cr_resp !== 5'h01) begin bad++; $display("FAIL data_cr_resp: got %h want 01", ccu_resp[0].cr_resp); end
        total++; if (ccu_resp[0].cd_valid !== 1'b0) begin bad++; $display("FAIL data_early_cd_valid: got %0b want 0", ccu_resp[0].cd_valid); end
        total++; if (core_req[0].cd_ready !== 1'b0) begin bad++; $display("FAIL data_early_cd_ready: got %0b want 0", core_req[0].cd_ready); end
        tick();
        core_resp[0].cr_valid = 1'b0;
        ccu_req[0].ac_valid   = 1'b1;
        ccu_req[0].ac.addr    = 64'h8000_00c0;
        #1;
        total++; if (ccu_resp[0].cd_valid !== 1'b1) begin bad++; $display("FAIL data_b1_valid: got %0b want 1", ccu_resp[0].cd_valid); end
        total++; if (ccu_resp[0].cd.data !== 64'h11) begin bad++; $display("FAIL data_b1_data: got %h want 11", ccu_resp[0].cd.data); end
        total++; if (core_req[0].cd_ready !== 1'b1) begin bad++; $display("FAIL data_b1_ready: got %0b want 1", core_req[0].cd_ready); end
        total++; if (ccu_resp[0].ac_ready !== 1'b0) begin bad++; $display("FAIL data_b1_ac_blocked: got %0b want 0", ccu_resp[0].ac_ready); end
        tick();
        core_resp[0].cd.data = 64'h22;
        core_resp[0].cd.last = 1'b1;
        #1;
        total++; if (ccu_resp[0].cd.data !== 64'h22) begin bad++; $display("FAIL data_b2_data: got %h want 22", ccu_resp[0].cd.data); end
        total++; if (ccu_resp[0].cd.last !== 1'b1) begin bad++; $display("FAIL data_b2_last: got %0b want 1", ccu_resp[0].cd.last); end
        total++; if (ccu_resp[0].cd_valid !== 1'b1) begin bad++; $display("FAIL data_b2_valid: got %0b want 1", ccu_resp[0].cd_valid); end
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL data_b2_ac_blocked: got %0b want 0", core_req[0].ac_valid); end
        tick();
        core_resp[0].cd_valid = 1'b0;
        #1;
        total++; if (ccu_resp[0].ac_ready !== 1'b1) begin bad++; $display("FAIL data_after_ac_ready: got %0b want 1", ccu_resp[0].ac_ready); end
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL data_after_ac_valid: got %0b want 1", core_req[0].ac_valid); end
        tick();
        finish_cr(0);
        clr_inputs();
        $display("test_data: snoop 80000080 with 2 CD beats done");
    endtask

    task automatic test_conflict();
        aw_push(0, 64'h8000_0048);
        ccu_req[0].ac_valid   = 1'b1;
        ccu_req[0].ac.addr    = 64'h8000_0080;
        core_resp[0].ac_ready = 1'b1;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL confl_other_line: got %0b want 1", core_req[0].ac_valid); end
        tick();
        finish_cr(0);
        ccu_req[0].ac_valid = 1'b1;
        ccu_req[0].ac.addr  = 64'h8000_0040;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL confl_stall_valid: got %0b want 0", core_req[0].ac_valid); end
        total++; if (ccu_resp[0].ac_ready !== 1'b0) begin bad++; $display("FAIL confl_stall_ready: got %0b want 0", ccu_resp[0].ac_ready); end
        tick();
        cresp[0].b_valid = 1'b1;
        creq[0].b_ready  = 1'b1;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL confl_b_cycle: got %0b want 0", core_req[0].ac_valid); end
        tick();
        cresp[0].b_valid = 1'b0;
        creq[0].b_ready  = 1'b0;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL confl_release_valid: got %0b want 1", core_req[0].ac_valid); end
        total++; if (ccu_resp[0].ac_ready !== 1'b1) begin bad++; $display("FAIL confl_release_ready: got %0b want 1", ccu_resp[0].ac_ready); end
        tick();
        finish_cr(0);
        clr_inputs();
        $display("test_conflict: wb 80000048 vs snoop 80000040/80000080 done");
    endtask

    task automatic test_simultaneous();
        aw_push(0, 64'h8000_0040);
        creq[0].aw_valid  = 1'b1;
        creq[0].aw.addr   = 64'h8000_0200;
        cresp[0].aw_ready = 1'b1;
        cresp[0].b_valid  = 1'b1;
        creq[0].b_ready   = 1'b1;
        tick();
        clr_inputs();
        ccu_req[0].ac_valid   = 1'b1;
        ccu_req[0].ac.addr    = 64'h8000_0040;
        core_resp[0].ac_ready = 1'b1;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL simul_old_line: got %0b want 1", core_req[0].ac_valid); end
        tick();
        finish_cr(0);
        ccu_req[0].ac_valid = 1'b1;
        ccu_req[0].ac.addr  = 64'h8000_0208;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL simul_new_line: got %0b want 0", core_req[0].ac_valid); end
        tick();
        cresp[0].b_valid = 1'b1;
        creq[0].b_ready  = 1'b1;
        tick();
        cresp[0].b_valid = 1'b0;
        creq[0].b_ready  = 1'b0;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL simul_cnt_one: got %0b want 1", core_req[0].ac_valid); end
        tick();
        finish_cr(0);
        clr_inputs();
        $display("test_simultaneous: aw 80000200 + b same cycle done");
    endtask

    task automatic test_independence();
        aw_push(0, 64'h8000_0300);
        for (int p = 0; p < 2; p++) begin
            ccu_req[p].ac_valid   = 1'b1;
            ccu_req[p].ac.addr    = 64'h8000_0300;
            core_resp[p].ac_ready = 1'b1;
        end
        #1;
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL indep_p0_stall: got %0b want 0", core_req[0].ac_valid); end
        total++; if (ccu_resp[1].ac_ready !== 1'b1) begin bad++; $display("FAIL indep_p1_ac: got %0b want 1", ccu_resp[1].ac_ready); end
        tick();
        ccu_req[1].ac_valid   = 1'b0;
        core_resp[1].cr_valid = 1'b1;
        core_resp[1].cr_resp  = 5'h01;
        ccu_req[1].cr_ready   = 1'b1;
        #1;
        total++; if (ccu_resp[1].cr_valid !== 1'b1) begin bad++; $display("FAIL indep_p1_cr: got %0b want 1", ccu_resp[1].cr_valid); end
        tick();
        core_resp[1].cr_valid = 1'b0;
        core_resp[1].cd_valid = 1'b1;
        core_resp[1].cd.data  = 64'h33;
        core_resp[1].cd.last  = 1'b1;
        ccu_req[1].cd_ready   = 1'b1;
        #1;
        total++; if (ccu_resp[1].cd_valid !== 1'b1) begin bad++; $display("FAIL indep_p1_cd: got %0b want 1", ccu_resp[1].cd_valid); end
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL indep_p0_still: got %0b want 0", core_req[0].ac_valid); end
        tick();
        core_resp[1].cd_valid = 1'b0;
        cresp[0].b_valid = 1'b1;
        creq[0].b_ready  = 1'b1;
        tick();
        cresp[0].b_valid = 1'b0;
        creq[0].b_ready  = 1'b0;
        #1;
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL indep_p0_release: got %0b want 1", core_req[0].ac_valid); end
        tick();
        finish_cr(0);
        clr_inputs();
        $display("test_independence: p0 stalled, p1 snoop with data done");
    endtask

    task automatic test_reset_mid();
        aw_push(0, 64'h8000_0400);
        ccu_req[1].ac_valid   = 1'b1;
        ccu_req[1].ac.addr    = 64'h8000_0500;
        core_resp[1].ac_ready = 1'b1;
        tick();
        ccu_req[1].ac_valid   = 1'b0;
        core_resp[1].cr_valid = 1'b1;
        core_resp[1].cr_resp  = 5'h01;
        ccu_req[1].cr_ready   = 1'b1;
        tick();
        core_resp[1].cr_valid = 1'b0;
        core_resp[1].cd_valid = 1'b1;
        core_resp[1].cd.data  = 64'h44;
        core_resp[1].cd.last  = 1'b0;
        ccu_req[1].cd_ready   = 1'b1;
        #1;
        total++; if (ccu_resp[1].cd_valid !== 1'b1) begin bad++; $display("FAIL rmid_cd_before: got %0b want 1", ccu_resp[1].cd_valid); end
        rst = 1'b1;
        ccu_req[0].ac_valid   = 1'b1;
        ccu_req[0].ac.addr    = 64'h8000_0400;
        core_resp[0].ac_ready = 1'b1;
        #1;
        total++; if (ccu_resp[1].cd_valid !== 1'b0) begin bad++; $display("FAIL rmid_cd_valid: got %0b want 0", ccu_resp[1].cd_valid); end
        total++; if (core_req[1].cd_ready !== 1'b0) begin bad++; $display("FAIL rmid_cd_ready: got %0b want 0", core_req[1].cd_ready); end
        total++; if (core_req[0].ac_valid !== 1'b0) begin bad++; $display("FAIL rmid_ac_valid: got %0b want 0", core_req[0].ac_valid); end
        total++; if (ccu_resp[0].ac_ready !== 1'b0) begin bad++; $display("FAIL rmid_ac_ready: got %0b want 0", ccu_resp[0].ac_ready); end
        tick();
        rst = 1'b0;
        ccu_req[1].ac_valid = 1'b1;
        #1;
        total++; if (ccu_resp[1].cd_valid !== 1'b0) begin bad++; $display("FAIL rmid_idle_cd: got %0b want 0", ccu_resp[1].cd_valid); end
        total++; if (core_req[1].ac_valid !== 1'b1) begin bad++; $display("FAIL rmid_p1_ac: got %0b want 1", core_req[1].ac_valid); end
        total++; if (core_req[0].ac_valid !== 1'b1) begin bad++; $display("FAIL rmid_wb_cleared: got %0b want 1", core_req[0].ac_valid); end
        tick();
        core_resp[1].cd_valid = 1'b0;
        ccu_req[0].ac_valid = 1'b0;
        finish_cr(1);
        finish_cr(0);
        clr_inputs();
        $display("test_reset_mid: reset during WAIT_CD done");
    endtask

    initial begin
        clr_inputs();
        tick();
        test_reset();
        test_plain();
        test_data();
        test_conflict();
        test_simultaneous();
        test_independence();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccu_snoop_gate.md
# ccu_snoop_gate

Per-port ACE snoop-channel gate between the cache-coherency unit (CCU) and the cores' D-caches. It sits on the snoop path, CCU to core, the opposite direction to the request dispatcher on the AW/AR path. It forwards AC snoop requests to each core and returns that core's CR/CD responses to the CCU. It enforces one outstanding snoop per port, and holds back any snoop that hits a cache line the same core is currently writing back, until that write's B response completes.

## Interface

Parameters:
- NoPorts, default 2: number of core ports.
- AxiAddrWidth, default 64: AC/AW address width.
- LineOffset, default $clog2(ariane_pkg::DCACHE_LINE_WIDTH/8): line byte-offset bits.
- req_t, default logic: core AXI/ACE request struct (monitored only).
- resp_t, default logic: core AXI/ACE response struct (monitored only).
- snoop_req_t, default logic: snoop request struct (ac_valid, ac.addr, cr_ready, cd_ready).
- snoop_resp_t, default logic: snoop response struct (ac_ready, cr_valid, cr_resp, cd_valid, cd.data, cd.last).

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- ccu_snoop_req_i, input, NoPorts x snoop_req_t: snoop requests from the CCU.
- ccu_snoop_resp_o, output, NoPorts x snoop_resp_t: snoop responses to the CCU.
- core_snoop_req_o, output, NoPorts x snoop_req_t: snoop requests to the cores.
- core_snoop_resp_i, input, NoPorts x snoop_resp_t: snoop responses from the cores.
- core_req_i, input, NoPorts x req_t: core write-channel monitor (aw_valid, aw.addr, b_ready).
- core_resp_i, input, NoPorts x resp_t: core write-channel monitor (aw_ready, b_valid).

## Operation

Per-port FSM with states IDLE, WAIT_CR and WAIT_CD:
- IDLE:
  - core_snoop_req_o.ac_valid = ccu ac_valid & ~conflict.
  - ccu ac_ready = core ac_ready & ~conflict.
  - cr_ready and cd_ready in both directions = 0.
  - An AC handshake moves the FSM to WAIT_CR.
- WAIT_CR:
  - ac_valid to the core = 0; ac_ready to the CCU = 0.
  - CR passes through combinationally (valid, ready, resp).
  - On the CR handshake: if cr_resp[0] (DataTransfer) = 1, go to WAIT_CD; otherwise go to IDLE.
- WAIT_CD:
  - CD passes through combinationally.
  - A CD handshake with cd.last = 1 returns the FSM to IDLE.
  - A CD handshake without last stays in WAIT_CD.
- CD beats presented by the core before WAIT_CD are not forwarded: cd_ready = 0 and the CCU sees cd_valid = 0.
- AC payload is always forwarded unmodified. Only valid and ready are gated.

Write-back tracker, per port:
- wb_cnt, 2 bits, counts outstanding writes.
- wb_line holds AxiAddrWidth-LineOffset bits.
- A core AW handshake (aw_valid & aw_ready) sets wb_line = aw.addr >> LineOffset and increments wb_cnt.
- A B handshake (b_valid & b_ready) decrements wb_cnt.
- Both handshakes in the same cycle: wb_cnt unchanged, wb_line updated.
- conflict = (wb_cnt != 0) & ((ccu ac.addr >> LineOffset) == wb_line).
- wb_cnt = 3 with a new AW (no B that cycle) is an assertion error; wb_cnt saturates at 3.
- wb_cnt = 0 with a B handshake is an assertion error; wb_cnt stays 0.

Ports are fully independent. There is no cross-port arbitration.

## Timing

- Forward path is zero-latency combinational: AC, CR and CD valid/ready/payload have no register stages.
- Only the FSM state, wb_cnt and wb_line are registered.
- After the last CR or CD handshake, a new AC can handshake in the next cycle.
- Conflict release:
  - A B handshake in cycle N, bringing wb_cnt to 0, releases a stalled AC in cycle N+1.
  - An AW in the same cycle as an AC does not block that AC. It blocks from the next cycle on.
- The CCU must hold ac_valid and its payload stable while stalled. Standard AXI valid/ready rules apply on both sides.
- While rst_i = 1:
  - Every FSM is in IDLE, wb_cnt = 0, wb_line = 0.
  - All output valid and ready signals are forced to 0 asynchronously.
- Reset mid-snoop drops the in-flight snoop with no response; both sides are expected to reset together.

## Structure

- The snoop_req_t and snoop_resp_t typedefs come from the shared ace typedef macros.
- The CR DataTransfer bit index is a constant in the shared ace package.
- LineOffset is derived from ariane_pkg.
- One natural sub-module, ccu_snoop_gate_port, holds the single-port FSM and tracker. The top level instantiates it NoPorts times with a generate loop.

## Test plan

- Plain snoop without data: AC addr 0x8000_0040, core CR resp 0x00 one cycle later. Expect one AC handshake on each side, CR forwarded, state back to IDLE, and a second AC accepted the next cycle.
- Snoop with data: CR resp 0x01, then 2 CD beats with last on beat 2. Expect both beats forwarded. AC is blocked until the cycle after beat 2.
- Write-back conflict: AW 0x8000_0048 accepted, then AC 0x8000_0040 (same 16 B line). Expect ac_valid to the core to stay 0 until the cycle after the B handshake. AC 0x8000_0080 in the same window passes immediately.
- Simultaneous events: AW handshake and B handshake in one cycle with wb_cnt = 1. Expect wb_cnt to stay 1 and wb_line to take the new address. An AC to the old line passes; an AC to the new line stalls.
- Port independence: port 0 stalled on a conflict while port 1 completes a snoop with data. Expect port 1 unaffected.
- Reset mid-snoop: rst_i asserted in WAIT_CD. Expect all valid/ready outputs to be 0 in the same cycle, and IDLE with wb_cnt = 0 after release.
